fetch_decode: RTL

- Front-end stage directly upstream of the execute stage.
- Fetches 16-bit LC-3 instructions from instruction memory over a req/ack handshake.
- Decodes each instruction into type / SR1 / SR2 / DR / imm / IP and presents the result to execute over a valid/ready handshake.
- Accepts PC redirects from execute (branch/jump next_IP) and halts on TRAP x25.

---
 rtl/lc3_pkg.sv | 63 ++++++
 rtl/fetch_decode_if.sv | 30 +++
 rtl/lc3_decoder.sv | 54 +++++
 rtl/fetch_decode.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// LC-3 front-end shared definitions: opcodes, decoded type codes, fetch FSM
// state encoding, the halt word and the decoded-output record.
package lc3_pkg;

  localparam logic [15:0] HALT_WORD = 16'hF025;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RSV  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [4:0] T_BR      = 5'b00000;
  localparam logic [4:0] T_JMP     = 5'b00001;
  localparam logic [4:0] T_JSR     = 5'b00010;
  localparam logic [4:0] T_JSRR    = 5'b00011;
  localparam logic [4:0] T_ADDR    = 5'b00100;
  localparam logic [4:0] T_ADDI    = 5'b00101;
  localparam logic [4:0] T_ANDR    = 5'b00110;
  localparam logic [4:0] T_ANDI    = 5'b00111;
  localparam logic [4:0] T_LD      = 5'b01000;
  localparam logic [4:0] T_LDR     = 5'b01001;
  localparam logic [4:0] T_LDI     = 5'b01010;
  localparam logic [4:0] T_LEA     = 5'b01011;
  localparam logic [4:0] T_ST      = 5'b01100;
  localparam logic [4:0] T_STR     = 5'b01101;
  localparam logic [4:0] T_STI     = 5'b01110;
  localparam logic [4:0] T_TRAP    = 5'b10000;
  localparam logic [4:0] T_NOT     = 5'b10001;
  localparam logic [4:0] T_RTI     = 5'b10010;
  localparam logic [4:0] T_ILLEGAL = 5'b11111;

  typedef enum logic [1:0] {S_REQ, S_OUT, S_DRAIN, S_HALT} state_e;

  typedef struct packed {
    logic [15:0] inst;
    logic [4:0]  itype;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic [15:0] imm;
    logic [15:0] ip;
  } dec_out_t;

  // Sign-extend the low w bits of v to 16 bits (w is a constant at every call).
  function automatic logic [15:0] sext(input logic [15:0] v, input int unsigned w);
    logic [15:0] t;
    t = v << (16 - w);
    return $signed(t) >>> (16 - w);
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Fetch/decode bus bundle: instruction-memory req/ack, decoded output to
// execute (valid/ready) and the redirect path back from execute.
// 'type' is a language keyword, so the decoded class travels as 'itype'.
interface fetch_decode_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        dec_valid;
  logic        exe_ready;
  logic [15:0] inst;
  logic [4:0]  itype;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [2:0]  DR;
  logic [15:0] imm;
  logic [15:0] IP;
  logic        redirect_valid;
  logic [15:0] redirect_ip;

  modport master (
    output imem_req, imem_addr, dec_valid, inst, itype, SR1, SR2, DR, imm, IP,
    input  imem_rdata, imem_ack, exe_ready, redirect_valid, redirect_ip
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, inst, itype, SR1, SR2, DR, imm, IP,
    output imem_rdata, imem_ack, exe_ready, redirect_valid, redirect_ip
  );
endinterface

// File: rtl/lc3_decoder.sv
// Combinational LC-3 instruction decoder (type / SR1 / SR2 / DR / imm).
// Kept standalone so the disassembly trace monitor can reuse it.
module lc3_decoder
  import lc3_pkg::*;
(
  input  logic [15:0] inst_i,
  output logic [4:0]  type_o,
  output logic [2:0]  sr1_o,
  output logic [2:0]  sr2_o,
  output logic [2:0]  dr_o,
  output logic [15:0] imm_o
);

  logic [3:0] op;
  assign op = inst_i[15:12];

  // Field extraction; stores carry their data register in [11:9] on SR2.
  always_comb begin
    type_o = T_ILLEGAL;
    imm_o  = '0;
    dr_o   = inst_i[11:9];
    sr1_o  = inst_i[8:6];
    sr2_o  = inst_i[2:0];
    case (op)
      OP_BR:   begin type_o = T_BR;  imm_o = sext(inst_i, 9); end
      OP_ADD:  begin
        type_o = inst_i[5] ? T_ADDI : T_ADDR;
        if (inst_i[5]) imm_o = sext(inst_i, 5);
      end
      OP_LD:   begin type_o = T_LD;  imm_o = sext(inst_i, 9); end
      OP_ST:   begin type_o = T_ST;  imm_o = sext(inst_i, 9); sr2_o = inst_i[11:9]; end
      OP_JSR:  begin
        type_o = inst_i[11] ? T_JSR : T_JSRR;
        if (inst_i[11]) imm_o = sext(inst_i, 11);
      end
      OP_AND:  begin
        type_o = inst_i[5] ? T_ANDI : T_ANDR;
        if (inst_i[5]) imm_o = sext(inst_i, 5);
      end
      OP_LDR:  begin type_o = T_LDR; imm_o = sext(inst_i, 6); end
      OP_STR:  begin type_o = T_STR; imm_o = sext(inst_i, 6); sr2_o = inst_i[11:9]; end
      OP_RTI:  type_o = T_RTI;
      OP_NOT:  type_o = T_NOT;
      OP_LDI:  begin type_o = T_LDI; imm_o = sext(inst_i, 9); end
      OP_STI:  begin type_o = T_STI; imm_o = sext(inst_i, 9); sr2_o = inst_i[11:9]; end
      OP_JMP:  type_o = T_JMP;
      OP_RSV:  type_o = T_ILLEGAL;
      OP_LEA:  begin type_o = T_LEA; imm_o = sext(inst_i, 9); end
      OP_TRAP: begin type_o = T_TRAP; imm_o = {8'h00, inst_i[7:0]}; end
      default: type_o = T_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// LC-3 fetch/decode front end: fetches over req/ack, decodes, hands off to
// execute over valid/ready, takes redirects and halts on TRAP x25.
// Optional fetch watchdog: define FD_TIMEOUT_EN.
module fetch_decode
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC       = 16'h3000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_decode_if.master bus,
  output logic           halted,
  output logic           fetch_err
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drain_addr_q, drain_addr_d;
  dec_out_t    out_q, out_d;
  logic        ld_dec, ld_bad, timeout;

  logic [4:0]  dec_type;
  logic [2:0]  dec_sr1, dec_sr2, dec_dr;
  logic [15:0] dec_imm;

  lc3_decoder u_dec (
    .inst_i (bus.imem_rdata),
    .type_o (dec_type),
    .sr1_o  (dec_sr1),
    .sr2_o  (dec_sr2),
    .dr_o   (dec_dr),
    .imm_o  (dec_imm)
  );

  // Next state, PC and output-record update; redirect outranks everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    out_d        = out_q;
    ld_dec       = 1'b0;
    ld_bad       = 1'b0;
    case (state_q)
      S_REQ: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_ip;
          // An un-acked request is committed: keep presenting the old address.
          if (!bus.imem_ack) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (bus.imem_ack) begin
          ld_dec = 1'b1;
        end else if (timeout) begin
          ld_bad = 1'b1;
        end
      end
      S_OUT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_ip;
          state_d = S_REQ;
        end else if (bus.exe_ready) begin
          state_d = (out_q.inst == HALT_WORD) ? S_HALT : S_REQ;
        end
      end
      S_DRAIN: begin
        if (bus.redirect_valid) pc_d = bus.redirect_ip;
        // Once the stale request completes there is nothing left to drain,
        // even if a further redirect lands in the same cycle.
        if (bus.imem_ack) state_d = S_REQ;
        else if (!bus.redirect_valid && timeout) ld_bad = 1'b1;
      end
      S_HALT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_ip;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (ld_dec) begin
      out_d.inst  = bus.imem_rdata;
      out_d.itype = dec_type;
      out_d.sr1   = dec_sr1;
      out_d.sr2   = dec_sr2;
      out_d.dr    = dec_dr;
      out_d.imm   = dec_imm;
      out_d.ip    = pc_q + 16'd1;
      pc_d        = pc_q + 16'd1;
      state_d     = S_OUT;
    end
    // Abandoned fetch is reported to execute as an ILLEGAL bubble.
    if (ld_bad) begin
      out_d       = '0;
      out_d.itype = T_ILLEGAL;
      out_d.ip    = pc_q + 16'd1;
      pc_d        = pc_q + 16'd1;
      state_d     = S_OUT;
    end
  end

  // State, PC and decoded-output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      out_q        <= out_d;
    end
  end

`ifdef FD_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        ferr_q;
  logic        waiting;

  assign waiting = (state_q == S_REQ) || (state_q == S_DRAIN);
  // >= rather than == so a counter pushed past the limit by drain redirects
  // still fires.
  assign timeout = waiting && !bus.imem_ack && (cnt_q >= 16'(TIMEOUT_CYCLES - 1));
  assign cnt_d   = (waiting && !bus.imem_ack && (state_d == state_q)) ? cnt_q + 16'd1 : '0;

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ferr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (ld_bad) ferr_q <= 1'b1;
    end
  end

  assign fetch_err = ferr_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  // Request is quiet while reset is held even though the state is S_REQ.
  assign bus.imem_req  = rst_n && ((state_q == S_REQ) || (state_q == S_DRAIN));
  assign bus.imem_addr = !rst_n ? 16'h0000 : ((state_q == S_DRAIN) ? drain_addr_q : pc_q);
  assign bus.dec_valid = (state_q == S_OUT);
  assign bus.inst      = out_q.inst;
  assign bus.itype     = out_q.itype;
  assign bus.SR1       = out_q.sr1;
  assign bus.SR2       = out_q.sr2;
  assign bus.DR        = out_q.dr;
  assign bus.imm       = out_q.imm;
  assign bus.IP        = out_q.ip;
  assign halted        = (state_q == S_HALT);

endmodule
